controle_multiciclo: RTL and testbench
======================================

Name: controle_multiciclo

Overview:
- Multi-cycle control unit for the 8-bit nRISC datapath; sits directly upstream of the ALU.
- Latches the fetched instruction into an internal IR and sequences FETCH/DECODE/EXEC/MEM/WB.
- Drives ula_op, operand select, register-file, memory and PC controls; consumes the ALU zero flag to resolve BEQ.
- Counts retired instructions for debug.

Parameters:
- DATA_W, 8, instruction width; opcode is always IR[7:5].
- CONT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- instrucao  in  DATA_W  instruction word from instruction memory
- zero  in  1  ALU zero flag
- mem_ready  in  1  data memory completes the current access this cycle
- ir  out  DATA_W  latched instruction register, to datapath field decode
- ir_load  out  1  datapath/IR fetch strobe
- pc_write  out  1  PC update enable
- pc_src  out  2  00 = PC+1, 01 = PC+imm (branch), 10 = jump target
- ula_op  out  3  ALU operation code
- ula_src  out  1  0 = register Dado2, 1 = immediate
- reg_write  out  1  register-file write enable
- mem_read  out  1  data memory read request
- mem_write  out  1  data memory write request
- mem_to_reg  out  1  writeback select, 1 = memory data
- halted  out  1  HALT state reached
- instr_count  out  CONT_W  retired instructions

Behaviour:
- Opcodes (IR[7:5]): 000 LOAD, 001 LA, 010 STORE, 011 ADD, 100 ADDI, 101 BEQ, 110 JUMP, 111 HALT.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset (synchronous): state = FETCH, ir = 0, instr_count = 0, halted = 0. While reset is high, every control output is forced 0. Reset mid-instruction aborts the instruction with no write; the first FETCH follows the cycle after reset drops.
- FETCH: ir_load = 1, pc_write = 1, pc_src = 00; IR <= instrucao; go to DECODE.
- DECODE: all strobes 0. JUMP asserts pc_write with pc_src = 10, retires, and goes to FETCH. HALT goes to HALT. All other opcodes go to EXEC.
- EXEC, ula_op/ula_src by opcode: LOAD 000/1, LA 001/1, STORE 010/1, ADD 011/0, ADDI 011/1, BEQ 101/0.
- EXEC, next state: LOAD and STORE go to MEM; LA, ADD and ADDI go to WB. BEQ sets pc_write = zero (Mealy, same cycle) with pc_src = 01, retires, and goes to FETCH.
- MEM: ula_op/ula_src held from EXEC. mem_read = 1 (LOAD) or mem_write = 1 (STORE), held steady until mem_ready = 1. On mem_ready, LOAD goes to WB; STORE retires and goes to FETCH. mem_ready is ignored in all other states.
- WB: reg_write = 1 and mem_to_reg = (opcode == LOAD); ula_op/ula_src held; retire; go to FETCH.
- HALT: halted = 1, all strobes 0; leaves only on reset. HALT is not counted as retired.
- Retire means instr_count increments by 1 on the clock edge leaving the final state; it wraps from all-ones to 0.
- Cycle counts: JUMP 2; BEQ 3; ADD/ADDI/LA/STORE 4; LOAD 5 (plus wait cycles). STORE is 4 and LOAD 5 with mem_ready already high.
- Outputs other than pc_write in BEQ are functions of state and IR only (Moore).
- Outside the states listed above: ula_op = 000, ula_src = 0.
- Any illegal state recovers to FETCH.

Decomposition:
- Shared package nrisc_pkg holds the opcode constants, ULA op constants (SOMA 000, LA 001, STORE 010, ADD 011, BEQ 101), pc_src encodings, and the state encoding.
- One sub-module, decod_ula: combinational opcode -> {ula_op, ula_src}, reusable by a future pipelined control.

Test Plan:
- ADD 8'b011_00_001 with mem_ready = 0: 4 cycles. reg_write high only in cycle 4; ula_op = 011, ula_src = 0 in EXEC; instr_count 0 -> 1.
- LOAD 8'b000_01_010 with mem_ready low 3 cycles then high: mem_read held 4 cycles; WB shows mem_to_reg = 1, reg_write = 1; total 8 cycles.
- BEQ 8'b101_00_011, zero = 1 in EXEC: pc_write = 1, pc_src = 01. Repeat with zero = 0: pc_write = 0. Both take 3 cycles and increment the count.
- JUMP then HALT (8'b110_00101, 8'b111_00000): JUMP pc_write with pc_src = 10 in DECODE; after HALT, halted = 1, count frozen, no strobes for 20 cycles.
- Reset asserted in MEM of a STORE: mem_write drops the same cycle; post-reset state FETCH, instr_count = 0, ir = 0.
- Preload instr_count to 16'hFFFF by 65535 JUMPs, then one more ADD: count wraps to 0.

Source files
------------

// File: rtl/nrisc_pkg.sv
// Shared definitions for the nRISC control path: opcodes, ALU operation codes,
// PC source encodings and the multi-cycle state encoding.
package nrisc_pkg;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_LA    = 3'b001,
        OP_STORE = 3'b010,
        OP_ADD   = 3'b011,
        OP_ADDI  = 3'b100,
        OP_BEQ   = 3'b101,
        OP_JUMP  = 3'b110,
        OP_HALT  = 3'b111
    } opcode_e;

    localparam logic [2:0] ULA_SOMA  = 3'b000;
    localparam logic [2:0] ULA_LA    = 3'b001;
    localparam logic [2:0] ULA_STORE = 3'b010;
    localparam logic [2:0] ULA_ADD   = 3'b011;
    localparam logic [2:0] ULA_BEQ   = 3'b101;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

endpackage

// File: rtl/controle_multiciclo_decod_ula.sv
// Combinational opcode -> ALU operation / operand-select decode, kept separate so
// a pipelined control can reuse it.
module decod_ula
    import nrisc_pkg::*;
(
    input  logic [2:0] opcode,
    output logic [2:0] ula_op,
    output logic       ula_src
);

    always_comb begin
        ula_op  = ULA_SOMA;
        ula_src = 1'b0;
        case (opcode_e'(opcode))
            OP_LOAD:  begin ula_op = ULA_SOMA;  ula_src = 1'b1; end
            OP_LA:    begin ula_op = ULA_LA;    ula_src = 1'b1; end
            OP_STORE: begin ula_op = ULA_STORE; ula_src = 1'b1; end
            OP_ADD:   begin ula_op = ULA_ADD;   ula_src = 1'b0; end
            OP_ADDI:  begin ula_op = ULA_ADD;   ula_src = 1'b1; end
            OP_BEQ:   begin ula_op = ULA_BEQ;   ula_src = 1'b0; end
            default:  begin ula_op = ULA_SOMA;  ula_src = 1'b0; end
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle control unit for the 8-bit nRISC datapath: holds the IR, sequences
// FETCH/DECODE/EXEC/MEM/WB and counts retired instructions.
module controle_multiciclo
    import nrisc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CONT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] instrucao,
    input  logic              zero,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] ir,
    output logic              ir_load,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic [2:0]        ula_op,
    output logic              ula_src,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              halted,
    output logic [CONT_W-1:0] instr_count
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [CONT_W-1:0]   count_q, count_d;
    logic                retire;
    opcode_e             op;
    logic [2:0]          dec_op;
    logic                dec_src;

    assign op = opcode_e'(ir_q[DATA_W-1:DATA_W-3]);

    decod_ula u_decod_ula (
        .opcode  (ir_q[DATA_W-1:DATA_W-3]),
        .ula_op  (dec_op),
        .ula_src (dec_src)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        retire     = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_INC;
        ula_op     = ULA_SOMA;
        ula_src    = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                pc_src   = PC_INC;
                ir_d     = instrucao;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                if (op == OP_JUMP) begin
                    pc_write = 1'b1;
                    pc_src   = PC_JUMP;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (op == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                ula_op  = dec_op;
                ula_src = dec_src;
                if (op == OP_LOAD || op == OP_STORE) begin
                    state_d = S_MEM;
                end else if (op == OP_BEQ) begin
                    // Branch decision is the only Mealy output: taken in the same cycle.
                    pc_write = zero;
                    pc_src   = PC_BRANCH;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                ula_op  = dec_op;
                ula_src = dec_src;
                if (op == OP_LOAD) begin
                    mem_read = 1'b1;
                end else begin
                    mem_write = 1'b1;
                end
                if (mem_ready) begin
                    if (op == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                ula_op     = dec_op;
                ula_src    = dec_src;
                reg_write  = 1'b1;
                mem_to_reg = (op == OP_LOAD);
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        count_d = count_q + CONT_W'(retire);

        // Reset aborts whatever is in flight, so no strobe may leak out this cycle.
        if (reset) begin
            ir_load    = 1'b0;
            pc_write   = 1'b0;
            pc_src     = PC_INC;
            ula_op     = ULA_SOMA;
            ula_src    = 1'b0;
            reg_write  = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            mem_to_reg = 1'b0;
            halted     = 1'b0;
        end
    end

    assign ir          = ir_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: an instruction-level model queues the
// expected control word for every cycle, a negedge monitor pops and compares.
module tb_controle_multiciclo;

    localparam int DATA_W = 8;
    localparam int CONT_W = 16;

    localparam logic [2:0] LOAD = 3'b000, LA = 3'b001, STORE = 3'b010, ADD = 3'b011,
                           ADDI = 3'b100, BEQ = 3'b101, JUMP = 3'b110, HALT = 3'b111;

    typedef struct packed {
        logic       ir_load;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [2:0] ula_op;
        logic       ula_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       halted;
    } ctrl_t;

    typedef struct {
        ctrl_t       ctrl;
        bit          chk_regs;
        logic [7:0]  ir;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [DATA_W-1:0] instrucao = '0;
    logic zero = 1'b0;
    logic mem_ready = 1'b0;

    logic [DATA_W-1:0] ir;
    logic ir_load, pc_write, ula_src, reg_write, mem_read, mem_write, mem_to_reg, halted;
    logic [1:0] pc_src;
    logic [2:0] ula_op;
    logic [CONT_W-1:0] instr_count;

    logic [DATA_W-1:0] w4_ir;
    logic w4_ir_load, w4_pc_write, w4_ula_src, w4_reg_write, w4_mem_read, w4_mem_write;
    logic w4_mem_to_reg, w4_halted;
    logic [1:0] w4_pc_src;
    logic [2:0] w4_ula_op;
    logic [3:0] w4_instr_count;

    exp_t        sbq[$];
    int          nChecks = 0;
    int          nFails = 0;
    logic [7:0]  modelIr = '0;
    int unsigned modelCnt = 0;

    always #5 clk = ~clk;

    controle_multiciclo #(.DATA_W(DATA_W), .CONT_W(CONT_W)) u_dut (
        .clk(clk), .reset(reset), .instrucao(instrucao), .zero(zero), .mem_ready(mem_ready),
        .ir(ir), .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src), .ula_op(ula_op),
        .ula_src(ula_src), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .halted(halted), .instr_count(instr_count)
    );

    // Narrow counter copy so counter wrap-around is reached within a short run.
    controle_multiciclo #(.DATA_W(DATA_W), .CONT_W(4)) u_dut_w4 (
        .clk(clk), .reset(reset), .instrucao(instrucao), .zero(zero), .mem_ready(mem_ready),
        .ir(w4_ir), .ir_load(w4_ir_load), .pc_write(w4_pc_write), .pc_src(w4_pc_src),
        .ula_op(w4_ula_op), .ula_src(w4_ula_src), .reg_write(w4_reg_write),
        .mem_read(w4_mem_read), .mem_write(w4_mem_write), .mem_to_reg(w4_mem_to_reg),
        .halted(w4_halted), .instr_count(w4_instr_count)
    );

    function automatic ctrl_t aluCtrl(input logic [2:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            LOAD:    begin c.ula_op = 3'b000; c.ula_src = 1'b1; end
            LA:      begin c.ula_op = 3'b001; c.ula_src = 1'b1; end
            STORE:   begin c.ula_op = 3'b010; c.ula_src = 1'b1; end
            ADD:     begin c.ula_op = 3'b011; c.ula_src = 1'b0; end
            ADDI:    begin c.ula_op = 3'b011; c.ula_src = 1'b1; end
            BEQ:     begin c.ula_op = 3'b101; c.ula_src = 1'b0; end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic checkOutput(input exp_t e);
        ctrl_t act, act4;
        act  = {ir_load, pc_write, pc_src, ula_op, ula_src, reg_write,
                mem_read, mem_write, mem_to_reg, halted};
        act4 = {w4_ir_load, w4_pc_write, w4_pc_src, w4_ula_op, w4_ula_src, w4_reg_write,
                w4_mem_read, w4_mem_write, w4_mem_to_reg, w4_halted};
        nChecks++;
        if (act !== e.ctrl) begin
            nFails++;
            $display("[TB] FAIL ctrl @%0t: got %b expected %b", $time, act, e.ctrl);
        end
        nChecks++;
        if (act4 !== e.ctrl) begin
            nFails++;
            $display("[TB] FAIL ctrl_w4 @%0t: got %b expected %b", $time, act4, e.ctrl);
        end
        if (e.chk_regs) begin
            nChecks++;
            if (ir !== e.ir) begin
                nFails++;
                $display("[TB] FAIL ir @%0t: got %h expected %h", $time, ir, e.ir);
            end
            nChecks++;
            if (instr_count !== e.cnt) begin
                nFails++;
                $display("[TB] FAIL instr_count @%0t: got %0d expected %0d",
                         $time, instr_count, e.cnt);
            end
            nChecks++;
            if (w4_instr_count !== e.cnt[3:0]) begin
                nFails++;
                $display("[TB] FAIL instr_count_w4 @%0t: got %0d expected %0d",
                         $time, w4_instr_count, e.cnt[3:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput(e);
        end
    end

    // One clock cycle: drive inputs, queue what the DUT must show, advance past the edge.
    task automatic applyStimulus(input logic rst, input logic [7:0] ins, input logic z,
                                 input logic mr, input ctrl_t c, input bit chkRegs);
        exp_t e;
        reset      = rst;
        instrucao  = ins;
        zero       = z;
        mem_ready  = mr;
        e.ctrl     = c;
        e.chk_regs = chkRegs;
        e.ir       = modelIr;
        e.cnt      = modelCnt[15:0];
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int n, input bit chkFirst);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 8'($urandom), 1'($urandom), 1'($urandom), '0,
                          (i > 0) || chkFirst);
            modelIr  = '0;
            modelCnt = 0;
        end
    endtask

    task automatic runInstr(input logic [7:0] ins, input logic zv, input int waits,
                            input bit abortInMem);
        logic [2:0] op;
        ctrl_t c;
        op = ins[7:5];

        c = '0; c.ir_load = 1'b1; c.pc_write = 1'b1; c.pc_src = 2'b00;
        applyStimulus(1'b0, ins, 1'($urandom), 1'($urandom), c, 1'b1);
        modelIr = ins;

        c = '0;
        if (op == JUMP) begin c.pc_write = 1'b1; c.pc_src = 2'b10; end
        applyStimulus(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), c, 1'b1);
        if (op == JUMP) begin modelCnt++; return; end
        if (op == HALT) return;

        c = aluCtrl(op);
        if (op == BEQ) begin
            c.pc_write = zv; c.pc_src = 2'b01;
            applyStimulus(1'b0, 8'($urandom), zv, 1'($urandom), c, 1'b1);
            modelCnt++;
            return;
        end
        applyStimulus(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), c, 1'b1);

        if (op == LOAD || op == STORE) begin
            for (int w = 0; w <= waits; w++) begin
                if (abortInMem && w == waits) begin
                    doReset(1, 1'b1);
                    return;
                end
                c = aluCtrl(op);
                c.mem_read  = (op == LOAD);
                c.mem_write = (op == STORE);
                applyStimulus(1'b0, 8'($urandom), 1'($urandom), (w == waits), c, 1'b1);
            end
            if (op == STORE) begin modelCnt++; return; end
        end

        c = aluCtrl(op); c.reg_write = 1'b1; c.mem_to_reg = (op == LOAD);
        applyStimulus(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), c, 1'b1);
        modelCnt++;
    endtask

    initial begin
        ctrl_t hc;
        @(posedge clk);
        #1;
        doReset(2, 1'b0);

        $display("[TB] directed: ADD, LOAD with waits, BEQ taken/not taken");
        runInstr(8'b011_00_001, 1'b0, 0, 1'b0);
        runInstr(8'b000_01_010, 1'b0, 3, 1'b0);
        runInstr(8'b101_00_011, 1'b1, 0, 1'b0);
        runInstr(8'b101_00_011, 1'b0, 0, 1'b0);

        $display("[TB] directed: reset in MEM of a STORE");
        runInstr(8'b010_10_110, 1'b0, 2, 1'b1);
        runInstr(8'b100_01_001, 1'b0, 0, 1'b0);

        $display("[TB] random instruction stream");
        for (int k = 0; k < 300; k++) begin
            logic [7:0] rins;
            rins = {3'($urandom_range(0, 6)), 5'($urandom)};
            runInstr(rins, 1'($urandom), $urandom_range(0, 3), 1'b0);
        end

        $display("[TB] directed: JUMP then HALT");
        runInstr(8'b110_00101, 1'b0, 0, 1'b0);
        runInstr(8'b111_00000, 1'b0, 0, 1'b0);
        hc = '0; hc.halted = 1'b1;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), hc, 1'b1);
        end

        doReset(1, 1'b1);
        runInstr(8'b011_11_000, 1'b0, 0, 1'b0);

        for (int k = 0; k < 4 && sbq.size() > 0; k++) @(negedge clk);
        #1;
        nChecks++;
        if (sbq.size() != 0) begin
            nFails++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
